// File: rtl/arb_priority_pkg.sv
// Shared types and width helpers for the fixed-priority grant/hold arbiter.
package arb_priority_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OFFER,
        ARB_HOLD
    } arb_state_t;

    // Index width for a requester count; a single requester still needs one bit.
    function automatic int arb_idw(input int w);
        return ($clog2(w) > 0) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/arb_priority_grant_hold_priority_index_lsb.sv
// Combinational lowest-set-bit encoder; index is zero when no bit is set.
module priority_index_lsb
    import arb_priority_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDW = arb_idw(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDW-1:0]   o_idx,
    output logic             o_found
);

    logic             found;
    logic [IDW-1:0]   idx;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < unsigned'(WIDTH); i++) begin
            if (i_vec[i] && !found) begin
                idx   = IDW'(i);
                found = 1'b1;
            end
        end
    end

    assign o_idx   = idx;
    assign o_found = found;

endmodule

// File: rtl/arb_priority_grant_hold.sv
// Registered fixed-priority arbiter: capture lowest active request, offer it
// with valid/ready, then hold until release or hold timeout.
module arb_priority_grant_hold
    import arb_priority_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16,
    localparam int IDW     = arb_idw(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_req,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [IDW-1:0]   o_grant_id,
    output logic [WIDTH-1:0] o_grant_oh,
    input  logic             i_release,
    output logic             o_busy,
    output logic             o_timeout
);

    localparam int HCW = ($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD != 0) ? HCW'(MAX_HOLD - 1) : '0;

    arb_state_t       state_q,    state_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [WIDTH-1:0] grant_oh_q, grant_oh_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic             timeout_q,  timeout_d;

    logic [IDW-1:0]   win_idx;
    logic             win_found;

    priority_index_lsb #(
        .WIDTH (WIDTH)
    ) u_pick (
        .i_vec   (i_req),
        .o_idx   (win_idx),
        .o_found (win_found)
    );

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        grant_oh_d = grant_oh_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (i_enable && win_found) begin
                    state_d    = ARB_OFFER;
                    grant_id_d = win_idx;
                    grant_oh_d = WIDTH'(1) << win_idx;
                end
            end
            ARB_OFFER: begin
                if (i_ready) begin
                    state_d    = ARB_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ARB_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                // Release takes precedence over a coincident timeout.
                if (i_release) begin
                    state_d    = ARB_IDLE;
                    grant_oh_d = '0;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
                    state_d    = ARB_IDLE;
                    grant_oh_d = '0;
                    timeout_d  = 1'b1;
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                grant_oh_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            grant_oh_q <= grant_oh_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_valid    = (state_q == ARB_OFFER);
    assign o_busy     = (state_q == ARB_HOLD);
    assign o_grant_id = grant_id_q;
    assign o_grant_oh = grant_oh_q;
    assign o_timeout  = timeout_q;

endmodule
